// File: rtl/onehot_decoder_pipe.sv
// Buffered 3-to-8 decoder: a small FIFO of {none, code} entries whose head is
// presented as a one-hot vector and a thermometer mask over valid/ready.
module onehot_decoder_pipe #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  input  logic       in_none,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_onehot,
  output logic [7:0] out_therm,
  output logic       out_none,
  output logic [3:0] level,
  output logic [7:0] total
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [3:0]    level_reg, level_next;
  logic [7:0]    total_reg, total_next;
  logic          push, pop;
  logic [3:0]    head;
  logic [2:0]    head_code;
  logic          head_none;

  // No bypass: readiness depends only on the registered level.
  assign in_ready  = (level_reg < 4'(DEPTH));
  assign out_valid = (level_reg != 4'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    total_next  = total_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
      total_next  = total_reg + 8'd1;
    end
    if (push && !pop) begin
      level_next = level_reg + 4'd1;
    end else if (pop && !push) begin
      level_next = level_reg - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      total_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      total_reg  <= total_next;
    end
  end

  // Storage is left uncleared on reset; stale entries are unreachable once level is 0.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_reg] <= {in_none, (in_none ? 3'd0 : in_code)};
    end
  end

  assign head      = mem[rd_ptr_reg];
  assign head_none = head[3];
  assign head_code = head[2:0];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_decode
      assign out_onehot[gi] = out_valid && !head_none && (head_code == 3'(gi));
      assign out_therm[gi]  = out_valid && !head_none && (3'(gi) <= head_code);
    end
  endgenerate

  assign out_none = out_valid && head_none;
  assign level    = level_reg;
  assign total    = total_reg;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Directed self-checking bench for onehot_decoder_pipe (DEPTH=4).
module tb_onehot_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic       in_none;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_onehot;
  logic [7:0] out_therm;
  logic       out_none;
  logic [3:0] level;
  logic [7:0] total;

  int checks = 0;
  int errors = 0;

  onehot_decoder_pipe #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_none    (in_none),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_therm  (out_therm),
    .out_none   (out_none),
    .level      (level),
    .total      (total)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_code = 3'd5; in_none = 1'b0; out_ready = 1'b0;
    step();
    step();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_onehot", 32'(out_onehot), 32'd0);
    chk("rst_therm", 32'(out_therm), 32'd0);
    chk("rst_none", 32'(out_none), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_total", 32'(total), 32'd0);

    // single decode of code 4
    rst = 1'b0; in_valid = 1'b1; in_code = 3'd4;
    step();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_onehot", 32'(out_onehot), 32'h10);
    chk("single_therm", 32'(out_therm), 32'h1F);
    chk("single_none", 32'(out_none), 32'd0);
    chk("single_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_pop_level", 32'(level), 32'd0);
    chk("single_pop_total", 32'(total), 32'd1);

    // none entry: code is ignored
    in_valid = 1'b1; in_none = 1'b1; in_code = 3'd6;
    step();
    in_valid = 1'b0; in_none = 1'b0;
    chk("none_valid", 32'(out_valid), 32'd1);
    chk("none_onehot", 32'(out_onehot), 32'd0);
    chk("none_therm", 32'(out_therm), 32'd0);
    chk("none_flag", 32'(out_none), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("none_pop_valid", 32'(out_valid), 32'd0);
    chk("none_pop_flag", 32'(out_none), 32'd0);
    chk("none_pop_total", 32'(total), 32'd2);

    // fill to full, then try a fifth push
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_code = 3'(c);
      step();
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_level", 32'(level), 32'd4);
    in_valid = 1'b1; in_code = 3'd7;
    step();
    in_valid = 1'b0;
    chk("full_reject_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_onehot_%0d", i), 32'(out_onehot), 32'(1) << i);
      step();
      if (i == 0) chk("drain_in_ready_rise", 32'(in_ready), 32'd1);
    end
    out_ready = 1'b0;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_total", 32'(total), 32'd6);

    // streaming with out_ready held high
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_code = 3'(c);
      step();
      chk($sformatf("stream_onehot_%0d", c), 32'(out_onehot), 32'(1) << c);
      chk($sformatf("stream_therm_%0d", c), 32'(out_therm), (32'(1) << (c + 1)) - 32'd1);
      chk($sformatf("stream_level_%0d", c), 32'(level), 32'd1);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("stream_end_level", 32'(level), 32'd0);
    chk("stream_total", 32'(total), 32'd14);

    // mid-operation reset discards stored entries
    for (int c = 1; c < 4; c++) begin
      in_valid = 1'b1; in_code = 3'(c);
      step();
    end
    in_valid = 1'b0;
    chk("mid_level3", 32'(level), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_total", 32'(total), 32'd0);
    in_valid = 1'b1; in_code = 3'd5;
    step();
    in_valid = 1'b0;
    chk("mid_new_head", 32'(out_onehot), 32'h20);
    out_ready = 1'b1;
    step();
    chk("mid_after_pop_valid", 32'(out_valid), 32'd0);
    chk("mid_after_pop_total", 32'(total), 32'd1);

    // total wraps: 254 more streamed pops reach 255, one more gives 0
    in_valid = 1'b1; in_code = 3'd2;
    for (int i = 0; i < 255; i++) step();
    chk("wrap_total_255", 32'(total), 32'd255);
    chk("wrap_level", 32'(level), 32'd1);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("wrap_total_0", 32'(total), 32'd0);
    chk("wrap_end_level", 32'(level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_pipe.md
# onehot_decoder_pipe

Buffered 3-to-8 decoder that performs the inverse of the team's 8:3 priority encoder. It accepts a stream of 3-bit priority codes plus a "no bit set" flag over a valid/ready handshake and stores them in a small FIFO. From the head entry it presents a one-hot vector and a thermometer mask (the set of lower-priority positions the code dominates). It sits downstream of the priority encoder in request/grant paths, turning encoded winners back into per-line grant and mask vectors.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..8.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a code on in_code/in_none.
- in_ready  output  1  block can accept an entry this cycle.
- in_code  input  3  encoded index 0..7; ignored when in_none=1.
- in_none  input  1  encoder saw an all-zero input vector; no valid index.
- out_valid  output  1  head entry is presented on the outputs.
- out_ready  input  1  consumer takes the head entry this cycle.
- out_onehot  output  8  one-hot decode of the head entry.
- out_therm  output  8  thermometer decode of the head entry.
- out_none  output  1  head entry was a none entry.
- level  output  4  number of occupied FIFO entries, 0..DEPTH.
- total  output  8  count of entries popped since reset; wraps 255 -> 0.

## Operation
- Push: occurs when in_valid && in_ready. Stores {in_none, in_code} at the write pointer. When in_none=1, the stored code is forced to 0.
- in_ready = (level < DEPTH), driven combinationally from registered level. There is no bypass path, so a full FIFO never accepts data, even when a pop happens in the same cycle.
- Pop: occurs when out_valid && out_ready. Advances the read pointer and increments total.
- out_valid = (level != 0).
- Decode is combinational from the registered head entry:
  - out_onehot[i] = (i == code) && !none.
  - out_therm[i] = (i <= code) && !none. Example: code 4 gives 8'b00011111; code 7 gives 8'hFF; code 0 gives 8'b00000001.
  - out_none = stored none bit.
- When out_valid=0, out_onehot, out_therm and out_none are all 0. They are never X.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. level is tracked separately so full and empty are unambiguous.
- Simultaneous push and pop (0 < level < DEPTH): both happen, and level is unchanged.
- Simultaneous push and pop with level == 0: only the push happens, because out_valid was 0.
- Data held on in_code while in_valid=0 is ignored.
- Ordering is strict FIFO. No entries are dropped or reordered.

## Timing
- Reset: at the first rising edge with rst=1, the block sets:
  - level=0 and both pointers=0
  - total=0
  - out_valid=0, out_onehot=0, out_therm=0, out_none=0
  - in_ready=1 (combinationally from level=0)
- While rst is high, pushes and pops are ignored. rst has priority over any handshake in the same cycle.
- Reset during operation discards all stored entries. The FIFO contents need not be cleared, because they are unreachable once level=0.
- Latency: an entry pushed at edge N appears with out_valid=1 in the cycle after edge N (1 cycle).
- With out_ready held at 1 and a continuous stream, throughput is one entry per cycle and level stays at 1.
- in_ready falls in the cycle after the push that makes level == DEPTH. It rises in the cycle after the first pop from full.
- total increments at the edge of each pop. total=255 plus one pop gives 0.

## Test plan
- **Reset:** assert rst for 2 cycles with in_valid=1 and in_code=5 -> level=0, out_valid=0, out_onehot=0, out_therm=0, in_ready=1, total=0.
- **Single decode:** push code 4 with out_ready=0 -> next cycle out_valid=1, out_onehot=8'b00010000, out_therm=8'b00011111, out_none=0, level=1.
- **None entry:** push in_none=1, in_code=6 -> out_onehot=0, out_therm=0, out_none=1. Pop it -> out_valid=0, total=1.
- **Fill to full (DEPTH=4, out_ready=0):**
  - Push codes 0,1,2,3 -> in_ready=0 and level=4.
  - A fifth in_valid with code 7 is not accepted.
  - Drain with out_ready=1 -> onehot sequence 01,02,04,08 and total=4.
- **Streaming:** push all 8 codes back-to-back with out_ready=1 -> level stays 1, out_onehot walks 01..80 and out_therm walks 01,03,07,...,FF, each one cycle after its push.
- **Mid-operation reset and total wrap:**
  - At level=3, pulse rst for 1 cycle -> out_valid=0 and level=0 on the next cycle, and the old entries never reappear.
  - After 256 pops, total returns to 0.
